// File: rtl/hex_display_ctrl_pkg.sv
// Purpose : shared constants and sizing helpers for the hex display controller.
// Latency : n/a (package only).
// Backpressure: n/a; contents are the active-low 7-seg code table, blank code, page-count math.
package hex_display_pkg;

  // All segments off (active-low).
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low segment codes for 0..F, bit6 = g ... bit0 = a.
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Pages needed to show data_w bits with num_digits hex digits per page.
  function automatic int calc_num_pages(int data_w, int num_digits);
    return (data_w + 4 * num_digits - 1) / (4 * num_digits);
  endfunction

  // Page index width; never narrower than one bit.
  function automatic int calc_pg_w(int num_pages);
    return (num_pages > 1) ? $clog2(num_pages) : 1;
  endfunction

endpackage

// File: rtl/hex_display_ctrl_if.sv
// Purpose : bus between the processor top level and hex_display_ctrl.
// Latency : n/a (wiring only).
// Backpressure: none; master drives capture/paging controls, slave returns seg_n/page/captured.
interface hex_display_ctrl_if
  import hex_display_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int NUM_DIGITS = 4
);
  localparam int PG_W = calc_pg_w(calc_num_pages(DATA_W, NUM_DIGITS));

  logic [DATA_W-1:0]       data_in;
  logic                    wr_en;
  logic                    mode;
  logic                    hold;
  logic                    auto_page;
  logic [PG_W-1:0]         page_sel;
  logic [7*NUM_DIGITS-1:0] seg_n;
  logic [PG_W-1:0]         page;
  logic                    captured;

  modport master (
    output data_in, wr_en, mode, hold, auto_page, page_sel,
    input  seg_n, page, captured
  );

  modport slave (
    input  data_in, wr_en, mode, hold, auto_page, page_sel,
    output seg_n, page, captured
  );

endinterface

// File: rtl/hex_display_ctrl_hex7seg.sv
// Purpose : 4-bit nibble to active-low 7-segment decoder (i_nibble -> o_seg_n).
// Latency : combinational, 0 cycles.
// Backpressure: none.
module hex7seg
  import hex_display_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg_n
);

  assign o_seg_n = SEG_LUT[i_nibble];

endmodule

// File: rtl/hex_display_ctrl.sv
// Purpose : paged 7-seg display of a captured bus value; ports clk, reset (sync, active-low),
//           bus (slave modport: data_in/wr_en/mode/hold/auto_page/page_sel in, seg_n/page/captured out).
// Latency : data_in -> shadow 1 cycle, shadow/page -> seg_n 1 cycle; no backpressure (display sink).
// Option  : define LEADING_ZERO_BLANK_EN to blank digits above the most significant nonzero nibble.
module hex_display_ctrl
  import hex_display_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int NUM_DIGITS = 4,
  parameter int PAGE_TICKS = 50_000_000
)(
  input  logic              clk,
  input  logic              reset,
  hex_display_ctrl_if.slave bus
);

  localparam int PAGE_W    = 4 * NUM_DIGITS;
  localparam int NUM_PAGES = calc_num_pages(DATA_W, NUM_DIGITS);
  localparam int PG_W      = calc_pg_w(NUM_PAGES);
  localparam int PAD_W     = NUM_PAGES * PAGE_W;
  localparam int PS_W      = (PAGE_TICKS > 2) ? $clog2(PAGE_TICKS) : 1;

  localparam logic [PG_W-1:0] LAST_PAGE = PG_W'(NUM_PAGES - 1);
  localparam logic [PS_W-1:0] LAST_TICK = PS_W'(PAGE_TICKS - 1);

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] SEG_RST_UPPER = SEG_BLANK;
`else
  localparam logic [6:0] SEG_RST_UPPER = 7'h40;
`endif

  logic [DATA_W-1:0]              r_shadow;
  logic [PG_W-1:0]                r_page;
  logic [PS_W-1:0]                r_presc;
  logic                           r_captured;
  logic [NUM_DIGITS-1:0][6:0]     r_seg_n;

  logic                           w_cap;
  logic [PG_W-1:0]                w_sel;
  logic [PAD_W-1:0]               w_padded;
  logic [PAGE_W-1:0]              w_page_dat;
  logic [NUM_DIGITS-1:0][6:0]     w_dec;
  logic [NUM_DIGITS-1:0][6:0]     w_seg_nxt;

  assign w_cap = !bus.hold && (!bus.mode || bus.wr_en);
  assign w_sel = (bus.page_sel > LAST_PAGE) ? LAST_PAGE : bus.page_sel;

  // Zero-extend the shadow to a whole number of pages so the top page's
  // missing nibbles read as 0.
  always_comb begin
    w_padded = '0;
    w_padded[DATA_W-1:0] = r_shadow;
  end

  always_comb begin
    w_page_dat = '0;
    for (int p = 0; p < NUM_PAGES; p++) begin
      if (r_page == PG_W'(p)) w_page_dat = w_padded[p*PAGE_W +: PAGE_W];
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    hex7seg u_dec (
      .i_nibble (w_page_dat[4*g +: 4]),
      .o_seg_n  (w_dec[g])
    );
  end

  always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
    logic w_seen;
    w_seen    = 1'b0;
`endif
    w_seg_nxt = w_dec;
`ifdef LEADING_ZERO_BLANK_EN
    // Walk down from the top digit; blank until the first nonzero nibble.
    // Digit 0 is never considered so an all-zero page still shows "0".
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      if (w_page_dat[4*i +: 4] != 4'h0) w_seen = 1'b1;
      if (!w_seen) w_seg_nxt[i] = SEG_BLANK;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_shadow   <= '0;
      r_page     <= '0;
      r_presc    <= '0;
      r_captured <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        r_seg_n[i] <= (i == 0) ? 7'h40 : SEG_RST_UPPER;
      end
    end else begin
      r_captured <= w_cap;
      r_seg_n    <= w_seg_nxt;
      if (w_cap) r_shadow <= bus.data_in;

      if (NUM_PAGES == 1) begin
        r_page  <= '0;
        r_presc <= '0;
      end else if (w_cap && bus.mode) begin
        // A write restarts the display on the low word; beats a coincident terminal count.
        r_page  <= '0;
        r_presc <= '0;
      end else if (bus.auto_page) begin
        if (r_presc == LAST_TICK) begin
          r_presc <= '0;
          r_page  <= (r_page == LAST_PAGE) ? '0 : r_page + 1'b1;
        end else begin
          r_presc <= r_presc + 1'b1;
        end
      end else begin
        r_presc <= '0;
        r_page  <= w_sel;
      end
    end
  end

  assign bus.seg_n    = r_seg_n;
  assign bus.page     = r_page;
  assign bus.captured = r_captured;

endmodule
